char_sweep_sequencer: RTL and testbench
=======================================

# char_sweep_sequencer

Sequences the neuromorphic ASIC through all four character patterns and scores its classification output. On `start` it drives `char_select` 0→3. For each character it waits a settle interval, samples `network_output` for a fixed window, and records the majority class. It sits between the AXI configuration register block, which supplies the manual `char_select` value and receives status/results, and the ASIC pins.

## Interface
- `SETTLE_CYCLES`, default 1000: cycles to wait after changing `char_select` before sampling; legal range ≥1.
- `SAMPLE_COUNT`, default 16: `network_output` samples per character; legal range ≥1.
- `clk`  in  1  single clock for the block.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- `abort`  in  1  terminates an in-progress sweep.
- `cfg_char_select`  in  2  manual character from the config register; driven to the ASIC while IDLE.
- `network_output`  in  2  ASIC classification output.
- `char_select`  out  2  registered character select to the ASIC.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle pulse at sweep completion.
- `result`  out  8  winning class per character; `result[2i+1:2i]` is the winner for character i.
- `pass_mask`  out  4  bit i set when the winner for character i equals i.

## Operation
- States: IDLE, SETTLE, SAMPLE, EVAL, DONE.
- IDLE:
  - `char_select` <= `cfg_char_select` every cycle.
  - `start` → SETTLE with `idx`=0.
  - `result` and `pass_mask` are cleared to 0 on acceptance of `start`.
- SETTLE:
  - `char_select` <= `idx`.
  - Down-counter loaded with `SETTLE_CYCLES-1`; at 0 → SAMPLE.
  - `network_output` is ignored.
  - The four class counters are cleared on entry.
- SAMPLE:
  - Each cycle, the counter indexed by `network_output` increments.
  - After exactly `SAMPLE_COUNT` cycles → EVAL.
  - Counter width is `$clog2(SAMPLE_COUNT+1)`; counters never overflow.
- EVAL (1 cycle):
  - Winner is the class with the highest count; ties go to the lowest class index.
  - Write `result[2*idx+1:2*idx]` and `pass_mask[idx]`.
  - If `idx`==3 → DONE; else `idx`+1 → SETTLE.
- DONE (1 cycle): `done`=1, then → IDLE.
- `abort` in any non-IDLE state: → IDLE on the next edge.
  - `done` is not asserted.
  - `result` and `pass_mask` keep any entries already written.
  - `char_select` returns to `cfg_char_select` one cycle later.
- `start` while `busy` is ignored.
- `start` and `abort` in the same IDLE cycle: `abort` wins and the block stays IDLE.

## Timing
- Reset values: `char_select`=0, `busy`=0, `done`=0, `result`=8'h00, `pass_mask`=4'h0, state IDLE, `idx`=0, all counters 0.
- Reset during a sweep returns every output to its reset value at the next edge.
- `start` sampled high at edge 0:
  - SETTLE begins at cycle 1.
  - Each character occupies `SETTLE_CYCLES`+`SAMPLE_COUNT`+1 cycles.
  - `done` is high in cycle 1+4·(`SETTLE_CYCLES`+`SAMPLE_COUNT`+1).
  - `busy` is high from cycle 1 through the `done` cycle inclusive.
- A character's `result` and `pass_mask` bits are visible the cycle after its EVAL.
- `network_output` is sampled directly and must be synchronous to `clk`.

## Configuration
- `CHAR_SWEEP_CONTINUOUS_EN` defined:
  - DONE transitions to SETTLE with `idx`=0 instead of IDLE.
  - `done` pulses once per sweep.
  - `result` and `pass_mask` are not cleared between sweeps; each character's entry is overwritten at its EVAL.
  - Only `abort` or `rst` returns the block to IDLE.
- Undefined: single sweep per `start`, as described above.

## Structure
- `char_sweep_pkg` holds:
  - the state encoding localparams;
  - `NUM_CHARS`=4 and `CLASS_W`=2;
  - the counter-width function.
- Sub-module `char_vote_counter` contains the four class counters, clear/increment logic and the lowest-index-wins argmax. Its outputs are `winner[1:0]`.
- The sequencer FSM, settle counter, sample counter and result registers live in the top module.

## Test plan
All scenarios use `SETTLE_CYCLES`=4, `SAMPLE_COUNT`=8.
- Reset and idle: assert `rst` for 2 cycles with `cfg_char_select`=2 → all outputs 0 during reset; `char_select`=2 one cycle after `rst` drops; `busy`=0.
- Ideal ASIC: drive `network_output`=`char_select`, pulse `start` → `done` in cycle 53, `result`=8'hE4, `pass_mask`=4'hF.
- Votes and tie-break:
  - char 1 samples 4×class 1 and 4×class 3 → `result[3:2]`=1, `pass_mask[1]`=1.
  - char 2 all class 0 → `result[5:4]`=0, `pass_mask[2]`=0.
  - final `pass_mask`=4'hB.
- Settle masking: drive `network_output`=3 only during SETTLE cycles, correct values during SAMPLE → `pass_mask`=4'hF.
- Abort/contention:
  - `abort` during char 2 SAMPLE → `busy`=0 next cycle, no `done`, `pass_mask`=4'h3.
  - `start` while `busy` → ignored.
  - `start`+`abort` in the same cycle in IDLE → stays IDLE.
- Continuous (`CHAR_SWEEP_CONTINUOUS_EN`): `done` pulses in cycles 53 and 105, `busy` stays 1, `abort` → IDLE next cycle.

Source files
------------

// File: rtl/char_sweep_pkg.sv
// Shared types and constants for the character sweep sequencer.
// Optional build macro used by the top: CHAR_SWEEP_CONTINUOUS_EN.
package char_sweep_pkg;

  localparam int NUM_CHARS   = 4;
  localparam int NUM_CLASSES = 4;
  localparam int CLASS_W     = 2;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_SETTLE_ENC = 3'd1;
  localparam logic [2:0] ST_SAMPLE_ENC = 3'd2;
  localparam logic [2:0] ST_EVAL_ENC   = 3'd3;
  localparam logic [2:0] ST_DONE_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SETTLE = ST_SETTLE_ENC,
    ST_SAMPLE = ST_SAMPLE_ENC,
    ST_EVAL   = ST_EVAL_ENC,
    ST_DONE   = ST_DONE_ENC
  } state_e;

  // Width of a counter that must hold values 0..max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/char_sweep_sequencer_vote.sv
// Per-class vote counters for one character plus a lowest-index-wins argmax.
module char_vote_counter
  import char_sweep_pkg::*;
#(
  parameter int SAMPLE_COUNT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic [CLASS_W-1:0] sample,
  output logic [CLASS_W-1:0] winner
);

  localparam int CW = cnt_width(SAMPLE_COUNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_COUNT);

  logic [CW-1:0]      cnt_q [NUM_CLASSES];
  logic [CW-1:0]      cnt_d [NUM_CLASSES];
  logic [CW-1:0]      best_cnt_s;
  logic [CLASS_W-1:0] best_idx_s;

  // Next-count logic: clear wins, otherwise saturating increment of the voted class.
  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (inc && (sample == CLASS_W'(i)) && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Strict greater-than keeps the earlier (lower) class on a tie.
  always_comb begin
    best_cnt_s = cnt_q[0];
    best_idx_s = '0;
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (cnt_q[i] > best_cnt_s) begin
        best_cnt_s = cnt_q[i];
        best_idx_s = CLASS_W'(i);
      end else begin
        best_cnt_s = best_cnt_s;
      end
    end
  end

  assign winner = best_idx_s;

endmodule

// File: rtl/char_sweep_sequencer.sv
// Steps the ASIC through characters 0..3, votes on its output, records winners.
// Build macro CHAR_SWEEP_CONTINUOUS_EN: restart the sweep after DONE instead of idling.
module char_sweep_sequencer
  import char_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1000,
  parameter int SAMPLE_COUNT  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CLASS_W-1:0]     cfg_char_select,
  input  logic [CLASS_W-1:0]     network_output,
  output logic [CLASS_W-1:0]     char_select,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_CHARS*CLASS_W-1:0] result,
  output logic [NUM_CHARS-1:0]   pass_mask
);

  localparam int SET_W = cnt_width(SETTLE_CYCLES);
  localparam int SMP_W = cnt_width(SAMPLE_COUNT);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_W-1:0] SAMPLE_LOAD = SMP_W'(SAMPLE_COUNT - 1);

  state_e                       state_q, state_d;
  logic [CLASS_W-1:0]           idx_q, idx_d;
  logic [SET_W-1:0]             settle_cnt_q, settle_cnt_d;
  logic [SMP_W-1:0]             sample_cnt_q, sample_cnt_d;
  logic [CLASS_W-1:0]           char_select_q, char_select_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic [NUM_CHARS*CLASS_W-1:0] result_q, result_d;
  logic [NUM_CHARS-1:0]         pass_mask_q, pass_mask_d;
  logic [CLASS_W-1:0]           winner_s;
  logic                         vote_clr_s;
  logic                         vote_inc_s;

  assign vote_clr_s = (state_q == ST_SETTLE) || (state_q == ST_DONE);
  assign vote_inc_s = (state_q == ST_SAMPLE);

  char_vote_counter #(.SAMPLE_COUNT(SAMPLE_COUNT)) u_vote (
    .clk    (clk),
    .rst    (rst),
    .clr    (vote_clr_s),
    .inc    (vote_inc_s),
    .sample (network_output),
    .winner (winner_s)
  );

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    settle_cnt_d  = settle_cnt_q;
    sample_cnt_d  = sample_cnt_q;
    char_select_d = char_select_q;
    result_d      = result_q;
    pass_mask_d   = pass_mask_q;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          char_select_d = cfg_char_select;
          if (start && !abort) begin
            state_d      = ST_SETTLE;
            idx_d        = '0;
            settle_cnt_d = SETTLE_LOAD;
            result_d     = '0;
            pass_mask_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          char_select_d = idx_q;
          if (settle_cnt_q == '0) begin
            state_d      = ST_SAMPLE;
            sample_cnt_d = SAMPLE_LOAD;
          end else begin
            settle_cnt_d = settle_cnt_q - SET_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (sample_cnt_q == '0) begin
            state_d = ST_EVAL;
          end else begin
            sample_cnt_d = sample_cnt_q - SMP_W'(1);
          end
        end
        ST_EVAL: begin
          result_d[{idx_q, 1'b0} +: CLASS_W] = winner_s;
          pass_mask_d[idx_q]                 = (winner_s == idx_q);
          if (idx_q == CLASS_W'(NUM_CHARS - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_SETTLE;
            idx_d        = idx_q + CLASS_W'(1);
            settle_cnt_d = SETTLE_LOAD;
          end
        end
        ST_DONE: begin
`ifdef CHAR_SWEEP_CONTINUOUS_EN
          // DONE doubles as the first settle cycle of the next sweep.
          idx_d         = '0;
          char_select_d = '0;
          if (SETTLE_CYCLES == 1) begin
            state_d      = ST_SAMPLE;
            sample_cnt_d = SAMPLE_LOAD;
          end else begin
            state_d      = ST_SETTLE;
            settle_cnt_d = SETTLE_LOAD - SET_W'(1);
          end
`else
          state_d = ST_IDLE;
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      settle_cnt_q  <= '0;
      sample_cnt_q  <= '0;
      char_select_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      pass_mask_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      settle_cnt_q  <= settle_cnt_d;
      sample_cnt_q  <= sample_cnt_d;
      char_select_q <= char_select_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_q      <= result_d;
      pass_mask_q   <= pass_mask_d;
    end
  end

  assign char_select = char_select_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign pass_mask   = pass_mask_q;

endmodule

// File: tb/tb_char_sweep_sequencer.sv
// Directed bench for char_sweep_sequencer with a result scoreboard.
module tb_char_sweep_sequencer;

  localparam int SC    = 4;
  localparam int SN    = 8;
  localparam int PER   = SC + SN + 1;
  localparam int SWEEP = 4 * PER;
  localparam int DONE_C = 1 + SWEEP;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] pm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] cfg_char_select = 2'd0;
  logic [1:0] network_output = 2'd0;
  logic [1:0] char_select;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [3:0] pass_mask;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  logic [1:0] pat [4][8];

  always #5 clk = ~clk;

  char_sweep_sequencer #(.SETTLE_CYCLES(SC), .SAMPLE_COUNT(SN)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .cfg_char_select (cfg_char_select),
    .network_output  (network_output),
    .char_select     (char_select),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .pass_mask       (pass_mask)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scen 0 ideal, 1 votes/tie-break, 2 random
  task automatic set_pattern(input int scen);
    for (int ch = 0; ch < 4; ch++) begin
      for (int k = 0; k < 8; k++) begin
        case (scen)
          0: pat[ch][k] = 2'(ch);
          1: begin
            if (ch == 1) pat[ch][k] = (k < 4) ? 2'd1 : 2'd3;
            else if (ch == 2) pat[ch][k] = 2'd0;
            else pat[ch][k] = 2'(ch);
          end
          default: pat[ch][k] = 2'($urandom_range(0, 3));
        endcase
      end
    end
  endtask

  function automatic exp_t model(input int nchars);
    exp_t e;
    int   cnt [4];
    int   w;
    e = '0;
    for (int ch = 0; ch < nchars; ch++) begin
      for (int cl = 0; cl < 4; cl++) cnt[cl] = 0;
      for (int k = 0; k < 8; k++) cnt[int'(pat[ch][k])]++;
      w = 0;
      for (int cl = 1; cl < 4; cl++) if (cnt[cl] > cnt[w]) w = cl;
      e.res[2*ch +: 2] = 2'(w);
      e.pm[ch] = (w == ch);
    end
    return e;
  endfunction

  function automatic logic [1:0] drive_val(input int c, input bit noise);
    int p, ch, ph;
    p  = (c - 1) % SWEEP;
    ch = p / PER;
    ph = p % PER;
    if (ph >= SC && ph < SC + SN) return pat[ch][ph - SC];
    else return noise ? 2'd3 : 2'(ch);
  endfunction

  function automatic logic exp_done(input int c);
`ifdef CHAR_SWEEP_CONTINUOUS_EN
    return (c > 1) && ((c - 1) % SWEEP == 0);
`else
    return c == DONE_C;
`endif
  endfunction

  // Start at the next edge (edge 0), then run cycles 1..ncyc, checking every cycle.
  task automatic sweep(input bit noise, input int ncyc, input int extra_start, input int abort_c);
    exp_t e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      network_output = drive_val(c, noise);
      start = (c == extra_start);
      abort = (c == abort_c);
      check($sformatf("busy c%0d", c), busy, 1);
      check($sformatf("done c%0d", c), done, exp_done(c));
      if (c == 1) check("char_select c1", char_select, cfg_char_select);
      else check($sformatf("char_select c%0d", c), char_select, ((c - 2) % SWEEP) / PER);
      if (done === 1'b1) begin
        check("sb_pending", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("result", result, e.res);
          check("pass_mask", pass_mask, e.pm);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    exp_t e;
    // Reset and idle
    cfg_char_select = 2'd2;
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      check("rst char_select", char_select, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst result", result, 0);
      check("rst pass_mask", pass_mask, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle char_select", char_select, 2);
    check("idle busy", busy, 0);

`ifdef CHAR_SWEEP_CONTINUOUS_EN
    cfg_char_select = 2'd1;
    set_pattern(0);
    sb_q.push_back(model(4));
    sb_q.push_back(model(4));
    sweep(1'b0, 2 * SWEEP + 3, 0, 2 * SWEEP + 3);
    check("cont abort busy", busy, 0);
    check("cont abort done", done, 0);
`else
    // Ideal ASIC
    cfg_char_select = 2'd1;
    set_pattern(0);
    sb_q.push_back(model(4));
    sweep(1'b0, DONE_C, 0, 0);
    check("post busy", busy, 0);
    check("post done", done, 0);
    @(posedge clk); #1;
    check("post char_select", char_select, 1);

    // Votes and tie-break, with a start while busy
    set_pattern(1);
    sb_q.push_back(model(4));
    sweep(1'b0, DONE_C, 20, 0);

    // Settle masking
    set_pattern(0);
    sb_q.push_back(model(4));
    sweep(1'b1, DONE_C, 0, 0);

    // Random votes
    set_pattern(2);
    sb_q.push_back(model(4));
    sweep(1'b0, DONE_C, 0, 0);

    // Abort during char 2 SAMPLE (cycle 33)
    set_pattern(0);
    e = model(2);
    sweep(1'b0, 2 * PER + SC + 3, 0, 2 * PER + SC + 3);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort pass_mask", pass_mask, e.pm);
    check("abort result", result, e.res);
    @(posedge clk); #1;
    check("abort char_select", char_select, cfg_char_select);
    check("abort done+1", done, 0);

    // start+abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("sa busy", busy, 0);
      check("sa done", done, 0);
      @(posedge clk); #1;
    end

    // Reset mid-sweep
    set_pattern(0);
    sweep(1'b0, 30, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid rst busy", busy, 0);
    check("mid rst char_select", char_select, 0);
    check("mid rst result", result, 0);
    check("mid rst pass_mask", pass_mask, 0);
`endif

    check("sb drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
